uart_if_param: RTL and testbench
================================

Name: uart_if_param

Overview:
Parametrised successor to the monitor's fixed 8N1 UART interface. Provides a UART transmitter and receiver with configurable data width, FIFO depth and baud divisor, plus runtime-selectable parity and sticky error flags. Sits between the rx/tx pins and the monitor character loop; the CPU UART I/O path can use it directly.

Parameters:
DBITS, 8, data bits per frame (5..9), sent and received LSB first
DEPTH, 8, entries in each of the RX and TX FIFOs (power of 2, >=2)
BAUD_DIV, 868, clocks per bit (>=4); 868 gives 115200 baud at 100 MHz

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous assert, active-high
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output, registered
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled only at frame start
tx_wdata  in  DBITS  byte to transmit
tx_wten  in  1  push tx_wdata into TX FIFO
tx_fifo_full  out  1  TX FIFO holds DEPTH entries
tx_fifo_empty  out  1  TX FIFO empty and transmitter idle
rx_rden  in  1  pop RX FIFO head
rx_rdata  out  DBITS  RX FIFO head (first-word fall-through)
rx_fifo_dvalid  out  1  RX FIFO non-empty
rx_fifo_full  out  1  RX FIFO holds DEPTH entries
rx_fifo_cnt  out  $clog2(DEPTH)+1  RX FIFO occupancy
err_clr  in  1  clear all sticky flags
tx_overrun  out  1  sticky: push while TX full
rx_overrun  out  1  sticky: frame completed while RX full
rx_underrun  out  1  sticky: pop while RX empty
rx_frame_err  out  1  sticky: stop bit sampled 0
rx_parity_err  out  1  sticky: parity mismatch

Behaviour:
- Reset (async): tx=1; both FIFOs empty; rx_fifo_cnt=0; all flags 0; both FSMs IDLE; rx_rdata=0 while empty.
- FIFOs: circular buffers, pointers wrap mod DEPTH. Push to full is dropped and sets the matching overrun flag. Pop from empty is ignored; RX sets rx_underrun.
- Simultaneous push and pop on a full FIFO: both succeed and count is unchanged. On an empty FIFO: the pop is an underrun and the push succeeds.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with FIFO non-empty: pop the head, latch parity_mode, go to START, drive tx=0 at the same edge.
  - Each state lasts exactly BAUD_DIV clocks.
  - DATA shifts DBITS bits. PARITY is skipped when the mode is none. STOP drives 1 for one bit, then returns to IDLE.
  - Back-to-back bytes: the next start bit follows the stop bit with no idle gap.
  - Latency: tx_wten at edge k into an empty idle TX produces tx=0 after edge k+1.
- RX input: passes through a 2-flop synchroniser.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on a synchronised 1->0 transition, go to START with the counter loaded to BAUD_DIV/2.
  - START sample: if 1, treat as a glitch and return to IDLE with no flag. If 0, go to DATA and sample every BAUD_DIV clocks thereafter.
  - PARITY (when enabled): even means the XOR of data and parity bit is 0; odd means it is 1.
  - STOP sample: stop=1 and parity OK pushes the byte, and rx_fifo_cnt updates on the next edge. Stop=0 sets rx_frame_err, discards the byte and goes to WAIT_HIGH. Parity bad sets rx_parity_err and discards the byte.
  - WAIT_HIGH: returns to IDLE only after the synchronised rx is 1. A held break therefore yields exactly one frame error.
- err_clr has priority over a set event in the same cycle, but the FIFO action still occurs.
- Counters are sized $clog2(BAUD_DIV)+1. The bit counter is sized for DBITS. No arithmetic overflow is permitted.

Test Plan:
- DBITS=8, BAUD_DIV=8, parity none; push 0x55 -> tx low after edge k+1; bit pattern 0,1,0,1,0,1,0,1,0,1 at 8 clocks per bit; tx high after 80 clocks; tx_fifo_empty=1 afterwards.
- Loopback rx=tx, even parity; push 0xA3 then 0x0F -> rx_fifo_cnt reaches 2; pops return 0xA3 then 0x0F; 0xA3 frame carries parity bit 0; no flags set.
- DEPTH=4; drive 5 valid frames with no pops -> rx_fifo_cnt=4, rx_overrun=1, FIFO holds the first four bytes; err_clr clears the flag; a pop then push on full leaves count 4.
- Odd parity; inject 0x01 with parity bit 1 -> rx_parity_err=1, no push. Inject a 2-clock low glitch -> no state change, no flag.
- Stop bit forced 0 then rx held low for 30 bit times -> rx_frame_err=1 once, rx_fifo_cnt=0; the following valid 0x7E frame is received correctly.
- Assert rst mid-frame on both TX and RX -> tx=1 immediately, counts 0, flags 0. A pop while empty sets rx_underrun=1.

Source files
------------

// File: rtl/uart_if_param_if.sv
// Bus bundle between the parametrised UART and its user: serial pins, FIFO access,
// parity selection and sticky error flags.
interface uart_if_param_if #(
  parameter int unsigned DBITS = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             rx;
  logic             tx;
  logic [1:0]       parity_mode;
  logic [DBITS-1:0] tx_wdata;
  logic             tx_wten;
  logic             tx_fifo_full;
  logic             tx_fifo_empty;
  logic             rx_rden;
  logic [DBITS-1:0] rx_rdata;
  logic             rx_fifo_dvalid;
  logic             rx_fifo_full;
  logic [CntW-1:0]  rx_fifo_cnt;
  logic             err_clr;
  logic             tx_overrun;
  logic             rx_overrun;
  logic             rx_underrun;
  logic             rx_frame_err;
  logic             rx_parity_err;

  modport slave (
    input  rx, parity_mode, tx_wdata, tx_wten, rx_rden, err_clr,
    output tx, tx_fifo_full, tx_fifo_empty, rx_rdata, rx_fifo_dvalid, rx_fifo_full,
           rx_fifo_cnt, tx_overrun, rx_overrun, rx_underrun, rx_frame_err, rx_parity_err
  );

  modport master (
    output rx, parity_mode, tx_wdata, tx_wten, rx_rden, err_clr,
    input  tx, tx_fifo_full, tx_fifo_empty, rx_rdata, rx_fifo_dvalid, rx_fifo_full,
           rx_fifo_cnt, tx_overrun, rx_overrun, rx_underrun, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_if_param.sv
// UART transmitter and receiver with TX/RX FIFOs, runtime parity selection and sticky
// error flags. Frames are start, DBITS data (LSB first), optional parity, one stop bit.
module uart_if_param #(
  parameter int unsigned DBITS    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BAUD_DIV = 868
) (
  input logic            clk,
  input logic            rst,
  uart_if_param_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV) + 1;
  localparam int unsigned BitW = $clog2(DBITS);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
  localparam logic [BaudW-1:0] BaudHalf = BaudW'(BAUD_DIV / 2);
  localparam logic [BitW-1:0] BitLast = BitW'(DBITS - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

  function automatic logic par_en(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DBITS-1:0] tx_mem_q [DEPTH];
  logic [PtrW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic             tx_full, tx_pop, tx_push_ok, tx_ovr_set;

  assign tx_full    = (tx_cnt_q == CntFull);
  assign tx_push_ok = bus.tx_wten && (!tx_full || tx_pop);
  assign tx_ovr_set = bus.tx_wten && !tx_push_ok;

  always_comb begin
    tx_wptr_d = tx_push_ok ? tx_wptr_q + PtrW'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop ? tx_rptr_q + PtrW'(1) : tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push_ok && !tx_pop) tx_cnt_d = tx_cnt_q + CntW'(1);
    else if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem_q[tx_wptr_q] <= bus.tx_wdata;
  end

  // ---------------- TX FSM ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [BaudW-1:0] tx_baud_q, tx_baud_d;
  logic [BitW-1:0]  tx_bit_q, tx_bit_d;
  logic [DBITS-1:0] tx_sh_q, tx_sh_d, tx_head;
  logic [1:0]       tx_mode_q, tx_mode_d;
  logic             tx_par_q, tx_par_d, tx_line_q, tx_line_d, tx_load;

  assign tx_head = tx_mem_q[tx_rptr_q];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_mode_d  = tx_mode_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TxIdle: tx_load = (tx_cnt_q != '0);
      TxStart: begin
        if (tx_baud_q == '0) begin
          tx_state_d = TxData;
          tx_baud_d  = BaudLast;
          tx_bit_d   = '0;
          tx_line_d  = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
        end else begin
          tx_baud_d = tx_baud_q - BaudW'(1);
        end
      end
      TxData: begin
        if (tx_baud_q == '0) begin
          tx_baud_d = BaudLast;
          if (tx_bit_q == BitLast) begin
            tx_state_d = par_en(tx_mode_q) ? TxParity : TxStop;
            tx_line_d  = par_en(tx_mode_q) ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d  = tx_bit_q + BitW'(1);
            tx_line_d = tx_sh_q[0];
            tx_sh_d   = tx_sh_q >> 1;
          end
        end else begin
          tx_baud_d = tx_baud_q - BaudW'(1);
        end
      end
      TxParity: begin
        if (tx_baud_q == '0) begin
          tx_state_d = TxStop;
          tx_baud_d  = BaudLast;
          tx_line_d  = 1'b1;
        end else begin
          tx_baud_d = tx_baud_q - BaudW'(1);
        end
      end
      TxStop: begin
        if (tx_baud_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (tx_cnt_q != '0) tx_load = 1'b1;
          else tx_state_d = TxIdle;
        end else begin
          tx_baud_d = tx_baud_q - BaudW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_sh_d    = tx_head;
      tx_mode_d  = bus.parity_mode;
      tx_par_d   = (^tx_head) ^ (bus.parity_mode == 2'b10);
      tx_state_d = TxStart;
      tx_baud_d  = BaudLast;
      tx_line_d  = 1'b0;
    end
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [BaudW-1:0] rx_baud_q, rx_baud_d;
  logic [BitW-1:0]  rx_bit_q, rx_bit_d;
  logic [DBITS-1:0] rx_sh_q, rx_sh_d;
  logic [1:0]       rx_mode_q, rx_mode_d;
  logic             rx_pbit_q, rx_pbit_d;
  logic             rx_push_req, rx_ferr_set, rx_perr_set;

  always_comb begin
    rx_s1_d     = bus.rx;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_baud_d   = rx_baud_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_mode_d   = rx_mode_q;
    rx_pbit_d   = rx_pbit_q;
    rx_push_req = 1'b0;
    rx_ferr_set = 1'b0;
    rx_perr_set = 1'b0;
    if (rx_state_q != RxIdle && rx_state_q != RxWaitHigh && rx_baud_q != '0) begin
      rx_baud_d = rx_baud_q - BaudW'(1);
    end
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
          rx_baud_d  = BaudHalf;
          rx_mode_d  = bus.parity_mode;
        end
      end
      RxStart: begin
        if (rx_baud_q == '0) begin
          rx_state_d = rx_s2_q ? RxIdle : RxData;
          rx_baud_d  = BaudLast;
          rx_bit_d   = '0;
        end
      end
      RxData: begin
        if (rx_baud_q == '0) begin
          rx_sh_d   = {rx_s2_q, rx_sh_q[DBITS-1:1]};
          rx_baud_d = BaudLast;
          if (rx_bit_q == BitLast) rx_state_d = par_en(rx_mode_q) ? RxParity : RxStop;
          else rx_bit_d = rx_bit_q + BitW'(1);
        end
      end
      RxParity: begin
        if (rx_baud_q == '0) begin
          rx_pbit_d  = rx_s2_q;
          rx_state_d = RxStop;
          rx_baud_d  = BaudLast;
        end
      end
      RxStop: begin
        if (rx_baud_q == '0) begin
          if (!rx_s2_q) begin
            rx_ferr_set = 1'b1;
            rx_state_d  = RxWaitHigh;
          end else begin
            rx_state_d = RxIdle;
            if (par_en(rx_mode_q) && (((^rx_sh_q) ^ rx_pbit_q) != (rx_mode_q == 2'b10))) begin
              rx_perr_set = 1'b1;
            end else begin
              rx_push_req = 1'b1;
            end
          end
        end
      end
      RxWaitHigh: if (rx_s2_q) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [DBITS-1:0] rx_mem_q [DEPTH];
  logic [PtrW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
  logic             rx_full, rx_pop_ok, rx_push_ok, rx_ovr_set, rx_und_set;

  assign rx_full    = (rx_cnt_q == CntFull);
  assign rx_pop_ok  = bus.rx_rden && (rx_cnt_q != '0);
  assign rx_push_ok = rx_push_req && (!rx_full || rx_pop_ok);
  assign rx_ovr_set = rx_push_req && !rx_push_ok;
  assign rx_und_set = bus.rx_rden && (rx_cnt_q == '0);

  always_comb begin
    rx_wptr_d = rx_push_ok ? rx_wptr_q + PtrW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop_ok ? rx_rptr_q + PtrW'(1) : rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push_ok && !rx_pop_ok) rx_cnt_d = rx_cnt_q + CntW'(1);
    else if (!rx_push_ok && rx_pop_ok) rx_cnt_d = rx_cnt_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem_q[rx_wptr_q] <= rx_sh_q;
  end

  // ---------------- Sticky flags (clear wins over set) ----------------
  logic tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d, rx_und_q, rx_und_d;
  logic rx_ferr_q, rx_ferr_d, rx_perr_q, rx_perr_d;

  always_comb begin
    tx_ovr_d  = bus.err_clr ? 1'b0 : (tx_ovr_q | tx_ovr_set);
    rx_ovr_d  = bus.err_clr ? 1'b0 : (rx_ovr_q | rx_ovr_set);
    rx_und_d  = bus.err_clr ? 1'b0 : (rx_und_q | rx_und_set);
    rx_ferr_d = bus.err_clr ? 1'b0 : (rx_ferr_q | rx_ferr_set);
    rx_perr_d = bus.err_clr ? 1'b0 : (rx_perr_q | rx_perr_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_state_q <= TxIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_mode_q  <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_mode_q  <= '0;
      rx_pbit_q  <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      tx_ovr_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_und_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_mode_q  <= tx_mode_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_mode_q  <= rx_mode_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovr_q   <= tx_ovr_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_und_q   <= rx_und_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  assign bus.tx             = tx_line_q;
  assign bus.tx_fifo_full   = tx_full;
  assign bus.tx_fifo_empty  = (tx_cnt_q == '0) && (tx_state_q == TxIdle);
  assign bus.rx_rdata       = (rx_cnt_q == '0) ? '0 : rx_mem_q[rx_rptr_q];
  assign bus.rx_fifo_dvalid = (rx_cnt_q != '0);
  assign bus.rx_fifo_full   = rx_full;
  assign bus.rx_fifo_cnt    = rx_cnt_q;
  assign bus.tx_overrun     = tx_ovr_q;
  assign bus.rx_overrun     = rx_ovr_q;
  assign bus.rx_underrun    = rx_und_q;
  assign bus.rx_frame_err   = rx_ferr_q;
  assign bus.rx_parity_err  = rx_perr_q;
endmodule

// File: tb/tb_uart_if_param.sv
// Directed and randomised checks of uart_if_param (DBITS=8, DEPTH=4, BAUD_DIV=8) against
// a frame-level reference model.
module tb_uart_if_param;
  localparam int unsigned DBITS = 8;
  localparam int unsigned DEPTH = 4;
  localparam int BAUD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_en = 1'b0;
  logic rx_drv = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_if_param_if #(.DBITS(DBITS), .DEPTH(DEPTH)) bus ();
  assign bus.rx = loop_en ? bus.tx : rx_drv;

  uart_if_param #(.DBITS(DBITS), .DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({bus.tx_overrun, bus.rx_overrun, bus.rx_underrun, bus.rx_frame_err,
                bus.rx_parity_err});
  endfunction

  // Reference model: frame = start(0), data LSB first, optional parity, stop(1).
  function automatic logic par_on(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  function automatic logic par_of(input logic [7:0] d, input logic [1:0] m);
    return (m == 2'b10) ? ~(^d) : (^d);
  endfunction

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic [1:0] m);
    logic [15:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    n = 9;
    if (par_on(m)) begin
      f[9] = par_of(d, m);
      n = 10;
    end
    f[n] = 1'b1;
    return f;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                            input logic stopv, input bit pop_end);
    rx_drv = 1'b0;
    repeat (BAUD) step();
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BAUD) step();
    end
    if (has_par) begin
      rx_drv = pbit;
      repeat (BAUD) step();
    end
    rx_drv = stopv;
    for (int k = 0; k < BAUD; k++) begin
      if (pop_end && k == BAUD - 1) bus.rx_rden = 1'b1;
      step();
    end
    bus.rx_rden = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus.tx_wdata = d;
    bus.tx_wten  = 1'b1;
    step();
    bus.tx_wten  = 1'b0;
  endtask

  task automatic pop_rx();
    bus.rx_rden = 1'b1;
    step();
    bus.rx_rden = 1'b0;
  endtask

  task automatic clear_flags();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask

  task automatic wait_cnt(input int n, input int budget, input string tag);
    int t = 0;
    while (int'(bus.rx_fifo_cnt) != n && t < budget) begin
      step();
      t++;
    end
    chk(tag, 32'(t < budget), 32'd1);
  endtask

  task automatic watch_tx(input int nbits, output logic [15:0] bits);
    int t = 0;
    bits = '1;
    while (bus.tx !== 1'b0 && t < 400) begin
      step();
      t++;
    end
    chk("tx_start_seen", 32'(t < 400), 32'd1);
    repeat (BAUD / 2) step();
    for (int i = 0; i < nbits; i++) begin
      bits[i] = bus.tx;
      repeat (BAUD) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_f, got_f;
    logic [7:0]  d;
    logic [1:0]  m;
    logic [7:0]  exp_q[$];
    logic        ovr_exp;

    bus.parity_mode = 2'b00;
    bus.tx_wdata    = '0;
    bus.tx_wten     = 1'b0;
    bus.rx_rden     = 1'b0;
    bus.err_clr     = 1'b0;
    step();
    step();
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_cnt", 32'(bus.rx_fifo_cnt), 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_tx_empty", 32'(bus.tx_fifo_empty), 32'd1);
    chk("rst_rdata", 32'(bus.rx_rdata), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // TX waveform of 0x55, parity none
    exp_f = frame_bits(8'h55, 2'b00);
    push_tx(8'h55);
    chk("tx_idle_at_k", 32'(bus.tx), 32'd1);
    step();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BAUD; c++) begin
        if (b != 0 || c != 0) step();
        chk($sformatf("tx55_bit%0d", b), 32'(bus.tx), 32'(exp_f[b]));
      end
      if (b == 5) chk("tx_busy_not_empty", 32'(bus.tx_fifo_empty), 32'd0);
    end
    step();
    chk("tx55_idle", 32'(bus.tx), 32'd1);
    chk("tx55_empty", 32'(bus.tx_fifo_empty), 32'd1);

    // Loopback, even parity, 0xA3 then 0x0F
    loop_en = 1'b1;
    bus.parity_mode = 2'b01;
    repeat (4) step();
    push_tx(8'hA3);
    push_tx(8'h0F);
    watch_tx(11, got_f);
    chk("a3_parity_bit", 32'(got_f[9]), 32'(par_of(8'hA3, 2'b01)));
    chk("a3_frame", 32'(got_f), 32'(frame_bits(8'hA3, 2'b01)));
    wait_cnt(2, 400, "loop_cnt2");
    chk("loop_head0", 32'(bus.rx_rdata), 32'hA3);
    pop_rx();
    chk("loop_head1", 32'(bus.rx_rdata), 32'h0F);
    pop_rx();
    chk("loop_empty", 32'(bus.rx_fifo_dvalid), 32'd0);
    chk("loop_flags", flags(), 32'd0);

    // Randomised loopback bytes with random parity mode
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      m = 2'($urandom_range(0, 3));
      bus.parity_mode = m;
      push_tx(d);
      wait_cnt(1, 300, $sformatf("rand%0d_cnt", i));
      chk($sformatf("rand%0d_data", i), 32'(bus.rx_rdata), 32'(d));
      pop_rx();
      chk($sformatf("rand%0d_flags", i), flags(), 32'd0);
    end
    repeat (3 * BAUD) step();

    // RX overrun with DEPTH entries
    loop_en = 1'b0;
    rx_drv = 1'b1;
    bus.parity_mode = 2'b00;
    repeat (4) step();
    ovr_exp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b0, 1'b0, 1'b1, 1'b0);
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else ovr_exp = 1'b1;
    end
    repeat (2) step();
    chk("ovr_cnt", 32'(bus.rx_fifo_cnt), 32'(exp_q.size()));
    chk("ovr_full", 32'(bus.rx_fifo_full), 32'd1);
    chk("ovr_flag", 32'(bus.rx_overrun), 32'(ovr_exp));
    clear_flags();
    chk("ovr_clr", 32'(bus.rx_overrun), 32'd0);
    chk("ovr_head", 32'(bus.rx_rdata), 32'(exp_q[0]));
    d = 8'($urandom);
    send_frame(d, 1'b0, 1'b0, 1'b1, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(d);
    repeat (2) step();
    chk("popush_cnt", 32'(bus.rx_fifo_cnt), 32'(exp_q.size()));
    chk("popush_no_ovr", 32'(bus.rx_overrun), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.rx_rdata), 32'(exp_q.pop_front()));
      pop_rx();
    end
    chk("drain_cnt", 32'(bus.rx_fifo_cnt), 32'd0);

    // Odd parity with wrong parity bit, then a short glitch
    bus.parity_mode = 2'b10;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) step();
    chk("perr_flag", 32'(bus.rx_parity_err), 32'((^8'h01 ^ 1'b1) != 1'b1));
    chk("perr_cnt", 32'(bus.rx_fifo_cnt), 32'd0);
    clear_flags();
    rx_drv = 1'b0;
    repeat (2) step();
    rx_drv = 1'b1;
    repeat (12 * BAUD) step();
    chk("glitch_flags", flags(), 32'd0);
    chk("glitch_cnt", 32'(bus.rx_fifo_cnt), 32'd0);
    d = 8'($urandom);
    send_frame(d, 1'b1, par_of(d, 2'b10), 1'b1, 1'b0);
    repeat (2) step();
    chk("odd_ok_cnt", 32'(bus.rx_fifo_cnt), 32'd1);
    chk("odd_ok_data", 32'(bus.rx_rdata), 32'(d));
    chk("odd_ok_flags", flags(), 32'd0);
    pop_rx();

    // Stop bit 0 followed by a long break
    bus.parity_mode = 2'b00;
    send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    chk("ferr_flag", 32'(bus.rx_frame_err), 32'd1);
    chk("ferr_cnt", 32'(bus.rx_fifo_cnt), 32'd0);
    clear_flags();
    repeat (29 * BAUD) step();
    chk("break_single_err", 32'(bus.rx_frame_err), 32'd0);
    rx_drv = 1'b1;
    repeat (2 * BAUD) step();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step();
    chk("after_break_cnt", 32'(bus.rx_fifo_cnt), 32'd1);
    chk("after_break_data", 32'(bus.rx_rdata), 32'h7E);
    chk("after_break_flags", flags(), 32'd0);

    // Reset in the middle of TX and RX frames
    bus.tx_wten = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.tx_wdata = 8'($urandom);
      step();
    end
    bus.tx_wten = 1'b0;
    chk("tx_ovr_flag", 32'(bus.tx_overrun), 32'd1);
    chk("tx_full", 32'(bus.tx_fifo_full), 32'd1);
    rx_drv = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(bus.tx), 32'd1);
    chk("midrst_cnt", 32'(bus.rx_fifo_cnt), 32'd0);
    chk("midrst_flags", flags(), 32'd0);
    chk("midrst_tx_empty", 32'(bus.tx_fifo_empty), 32'd1);
    chk("midrst_rdata", 32'(bus.rx_rdata), 32'd0);
    rx_drv = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("postrst_tx", 32'(bus.tx), 32'd1);
    pop_rx();
    chk("underrun_flag", 32'(bus.rx_underrun), 32'd1);
    chk("underrun_cnt", 32'(bus.rx_fifo_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
